// File: rtl/pa_grad_update_if.sv
// Handshake and gradient/weight bus between the parallel adapter
// and its gradient update block.
interface pa_grad_update_if #(
   parameter int PA_KERNELS = 1,
   parameter int BATCH      = 4,
   parameter int BW         = 31
);
   logic                        init;
   logic                        grad_valid;
   logic [PA_KERNELS-1:0][BW:0] bpWchange;
   logic [PA_KERNELS-1:0][BW:0] bpBchange;
   logic [PA_KERNELS-1:0][BW:0] weights_PA;
   logic [PA_KERNELS-1:0][BW:0] biases_PA;
   logic                        busy;
   logic                        update_done;
   logic                        overrun;
   logic [$clog2(BATCH+1)-1:0]  sample_count;

   modport master (
      output init, grad_valid, bpWchange, bpBchange,
      input  weights_PA, biases_PA, busy, update_done,
      input  overrun, sample_count
   );

   modport slave (
      input  init, grad_valid, bpWchange, bpBchange,
      output weights_PA, biases_PA, busy, update_done,
      output overrun, sample_count
   );
endinterface

// File: rtl/pa_grad_update.sv
// Mini-batch gradient accumulator and SGD weight update for the
// parallel adapter; kernels are processed serially in FP32.
module pa_grad_update #(
   parameter int          PA_KERNELS = 1,
   parameter int          BATCH      = 4,
   parameter logic [31:0] LR_SCALED  = 32'h3C23D70A,
   parameter logic [31:0] INIT_W     = 32'h00000000,
   parameter logic [31:0] INIT_B     = 32'h00000000,
   parameter int          BW         = 31
) (
   input logic             clk,
   input logic             rst,
   pa_grad_update_if.slave io
);
   localparam int KW = (PA_KERNELS > 1) ? $clog2(PA_KERNELS) : 1;
   localparam int CW = $clog2(BATCH + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ACC   = 3'd1;
   localparam logic [2:0] S_SCALE = 3'd2;
   localparam logic [2:0] S_APPLY = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [31:0] QNAN = 32'h7FC00000;

   typedef logic [PA_KERNELS-1:0][BW:0] vec_t;

   // Normalise, handle subnormal underflow, round to nearest even
   // and pack. sig bit 63 carries weight 2^(e_in-127).
   function automatic logic [31:0] fp_pack(
      input logic               s,
      input logic signed [11:0] e_in,
      input logic [63:0]        sig_in
   );
      logic [63:0]        sig;
      logic [63:0]        mask;
      logic signed [11:0] e;
      logic [6:0]         lz;
      logic               st;
      logic               inc;
      logic [30:0]        mag;
      int                 sh;
      sig = sig_in;
      e   = e_in;
      lz  = 7'd0;
      st  = 1'b0;
      if (sig == 64'd0) return {s, 31'd0};
      for (int i = 0; i < 64; i++)
         if (sig[i]) lz = 7'(63 - i);
      sig = sig << lz;
      e   = e - $signed({5'd0, lz});
      if (e < 12'sd1) begin
         sh = 1 - int'(e);
         if (sh > 63) begin
            sig = {63'd0, |sig};
         end else begin
            mask = (64'd1 << sh) - 64'd1;
            st   = |(sig & mask);
            sig  = (sig >> sh) | {63'd0, st};
         end
         e = 12'sd0;
      end
      if (e > 12'sd254) return {s, 8'hFF, 23'd0};
      inc = sig[39] & ((|sig[38:0]) | sig[40]);
      mag = {e[7:0], sig[62:40]} + {30'd0, inc};
      return {s, mag};
   endfunction

   function automatic logic [31:0] fp_mul(
      input logic [31:0] a,
      input logic [31:0] b
   );
      logic               s;
      logic [7:0]         ea;
      logic [7:0]         eb;
      logic [23:0]        ma;
      logic [23:0]        mb;
      logic [47:0]        p;
      logic signed [11:0] e;
      s = a[31] ^ b[31];
      if (a[30:23] == 8'hFF && a[22:0] != 23'd0) return a;
      if (b[30:23] == 8'hFF && b[22:0] != 23'd0) return b;
      if (a[30:23] == 8'hFF)
         return (b[30:0] == 31'd0) ? QNAN : {s, 8'hFF, 23'd0};
      if (b[30:23] == 8'hFF)
         return (a[30:0] == 31'd0) ? QNAN : {s, 8'hFF, 23'd0};
      ea = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
      eb = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
      ma = {a[30:23] != 8'd0, a[22:0]};
      mb = {b[30:23] != 8'd0, b[22:0]};
      p  = ma * mb;
      e  = $signed({4'd0, ea}) + $signed({4'd0, eb}) - 12'sd126;
      return fp_pack(s, e, {p, 16'd0});
   endfunction

   function automatic logic [31:0] fp_add(
      input logic [31:0] a,
      input logic [31:0] b
   );
      logic [31:0] x;
      logic [31:0] y;
      logic [7:0]  ex;
      logic [7:0]  ey;
      logic [7:0]  d;
      logic [63:0] sx;
      logic [63:0] sy;
      logic [63:0] mask;
      logic [63:0] r;
      logic        st;
      if (a[30:23] == 8'hFF && a[22:0] != 23'd0) return a;
      if (b[30:23] == 8'hFF && b[22:0] != 23'd0) return b;
      if (a[30:23] == 8'hFF)
         return (b[30:23] == 8'hFF && b[31] != a[31]) ? QNAN : a;
      if (b[30:23] == 8'hFF) return b;
      // Larger magnitude first so the difference never goes negative.
      if (b[30:0] > a[30:0]) begin
         x = b;
         y = a;
      end else begin
         x = a;
         y = b;
      end
      ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
      ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
      sx = {1'b0, x[30:23] != 8'd0, x[22:0], 39'd0};
      sy = {1'b0, y[30:23] != 8'd0, y[22:0], 39'd0};
      d  = ex - ey;
      if (d > 8'd63) begin
         sy = {63'd0, |sy};
      end else begin
         mask = (64'd1 << d) - 64'd1;
         st   = |(sy & mask);
         sy   = (sy >> d) | {63'd0, st};
      end
      if (x[31] == y[31]) r = sx + sy;
      else r = sx - sy;
      if (x[31] != y[31] && r == 64'd0) return 32'd0;
      return fp_pack(x[31], $signed({4'd0, ex}) + 12'sd1, r);
   endfunction

   logic [2:0]    state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovr_q, ovr_d;
   vec_t          capw_q, capw_d;
   vec_t          capb_q, capb_d;
   vec_t          accw_q, accw_d;
   vec_t          accb_q, accb_d;
   vec_t          w_q, w_d;
   vec_t          b_q, b_d;

   logic [BW:0]   add_w_a, add_w_b;
   logic [BW:0]   add_b_a, add_b_b;
   logic [BW:0]   sum_w, sum_b;
   logic [BW:0]   prod_w, prod_b;
   logic          last_k;
   logic          busy;
   logic [CW-1:0] cnt_inc;

   assign busy    = (state_q != S_IDLE);
   assign last_k  = (k_q == KW'(PA_KERNELS - 1));
   assign cnt_inc = cnt_q + CW'(1);

   // Shared adder/multiplier operands for the kernel selected by k.
   always_comb begin
      add_w_a = accw_q[k_q];
      add_w_b = capw_q[k_q];
      add_b_a = accb_q[k_q];
      add_b_b = capb_q[k_q];
      if (state_q == S_APPLY) begin
         add_w_a = w_q[k_q];
         add_w_b = {~accw_q[k_q][BW], accw_q[k_q][BW-1:0]};
         add_b_a = b_q[k_q];
         add_b_b = {~accb_q[k_q][BW], accb_q[k_q][BW-1:0]};
      end
      sum_w  = fp_add(add_w_a, add_w_b);
      sum_b  = fp_add(add_b_a, add_b_b);
      prod_w = fp_mul(accw_q[k_q], LR_SCALED);
      prod_b = fp_mul(accb_q[k_q], LR_SCALED);
   end

   // Sequencer: capture, accumulate, scale, apply, then report.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      capw_d  = capw_q;
      capb_d  = capb_q;
      accw_d  = accw_q;
      accb_d  = accb_q;
      w_d     = w_q;
      b_d     = b_q;
      ovr_d   = io.grad_valid & busy;
      if (io.init) begin
         state_d = S_IDLE;
         k_d     = '0;
         cnt_d   = '0;
         accw_d  = '0;
         accb_d  = '0;
         w_d     = {PA_KERNELS{INIT_W}};
         b_d     = {PA_KERNELS{INIT_B}};
         ovr_d   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (io.grad_valid) begin
                  capw_d  = io.bpWchange;
                  capb_d  = io.bpBchange;
                  k_d     = '0;
                  state_d = S_ACC;
               end
            end
            S_ACC: begin
               accw_d[k_q] = sum_w;
               accb_d[k_q] = sum_b;
               k_d = k_q + KW'(1);
               if (last_k) begin
                  k_d   = '0;
                  cnt_d = cnt_inc;
                  state_d = (cnt_inc == CW'(BATCH)) ?
                            S_SCALE : S_IDLE;
               end
            end
            S_SCALE: begin
               accw_d[k_q] = prod_w;
               accb_d[k_q] = prod_b;
               k_d = k_q + KW'(1);
               if (last_k) begin
                  k_d     = '0;
                  state_d = S_APPLY;
               end
            end
            S_APPLY: begin
               w_d[k_q] = sum_w;
               b_d[k_q] = sum_b;
               k_d = k_q + KW'(1);
               if (last_k) begin
                  k_d     = '0;
                  state_d = S_DONE;
               end
            end
            S_DONE: begin
               accw_d  = '0;
               accb_d  = '0;
               cnt_d   = '0;
               state_d = S_IDLE;
            end
            default: begin
               k_d     = '0;
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State registers with asynchronous reset to the initial weights.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         cnt_q   <= '0;
         ovr_q   <= 1'b0;
         capw_q  <= '0;
         capb_q  <= '0;
         accw_q  <= '0;
         accb_q  <= '0;
         w_q     <= {PA_KERNELS{INIT_W}};
         b_q     <= {PA_KERNELS{INIT_B}};
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         ovr_q   <= ovr_d;
         capw_q  <= capw_d;
         capb_q  <= capb_d;
         accw_q  <= accw_d;
         accb_q  <= accb_d;
         w_q     <= w_d;
         b_q     <= b_d;
      end
   end

   assign io.weights_PA   = w_q;
   assign io.biases_PA    = b_q;
   assign io.busy         = busy;
   assign io.update_done  = (state_q == S_DONE);
   assign io.overrun      = ovr_q;
   assign io.sample_count = cnt_q;
endmodule

// File: tb/tb_pa_grad_update.sv
// Directed bench for pa_grad_update: reset/init, batch update,
// serial multi-kernel apply, overrun and abort.
module tb_pa_grad_update;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   // A: one kernel, batch of two, lr 0.25, init 1.0 / 0.5
   pa_grad_update_if #(.PA_KERNELS(1), .BATCH(2)) ia ();
   // B: three kernels, batch of one, lr 1.0, init 0
   pa_grad_update_if #(.PA_KERNELS(3), .BATCH(1)) ib ();
   // C: three kernels, batch of four, default lr, init 0
   pa_grad_update_if #(.PA_KERNELS(3), .BATCH(4)) ic ();

   pa_grad_update #(
      .PA_KERNELS(1), .BATCH(2), .LR_SCALED(32'h3E800000),
      .INIT_W(32'h3F800000), .INIT_B(32'h3F000000), .BW(31)
   ) ua (.clk(clk), .rst(rst), .io(ia));

   pa_grad_update #(
      .PA_KERNELS(3), .BATCH(1), .LR_SCALED(32'h3F800000),
      .INIT_W(32'h0), .INIT_B(32'h0), .BW(31)
   ) ub (.clk(clk), .rst(rst), .io(ib));

   pa_grad_update #(
      .PA_KERNELS(3), .BATCH(4), .LR_SCALED(32'h3C23D70A),
      .INIT_W(32'h0), .INIT_B(32'h0), .BW(31)
   ) uc (.clk(clk), .rst(rst), .io(ic));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic a_pulse(input logic [31:0] w, input logic [31:0] b);
      ia.bpWchange  = w;
      ia.bpBchange  = b;
      ia.grad_valid = 1'b1;
      tick();
      ia.grad_valid = 1'b0;
   endtask

   initial begin
      ia.init = 0; ia.grad_valid = 0; ia.bpWchange = '0; ia.bpBchange = '0;
      ib.init = 0; ib.grad_valid = 0; ib.bpWchange = '0; ib.bpBchange = '0;
      ic.init = 0; ic.grad_valid = 0; ic.bpWchange = '0; ic.bpBchange = '0;
      tick();
      tick();
      chk("rst_a_w", ia.weights_PA, 32'h3F800000);
      chk("rst_a_b", ia.biases_PA, 32'h3F000000);
      chk("rst_a_busy", ia.busy, 1'b0);
      chk("rst_a_cnt", ia.sample_count, 2'd0);
      chk("rst_a_done", ia.update_done, 1'b0);
      chk("rst_b_w", ib.weights_PA, 96'h0);
      chk("rst_c_cnt", ic.sample_count, 3'd0);
      rst = 1'b0;
      tick();

      // corrupt A with one sample, then init
      a_pulse(32'h40000000, 32'hBF800000);
      chk("a_busy_acc", ia.busy, 1'b1);
      tick();
      chk("a_cnt_one", ia.sample_count, 2'd1);
      chk("a_idle", ia.busy, 1'b0);
      ia.init = 1'b1;
      tick();
      ia.init = 1'b0;
      chk("a_init_cnt", ia.sample_count, 2'd0);
      chk("a_init_w", ia.weights_PA, 32'h3F800000);
      chk("a_init_b", ia.biases_PA, 32'h3F000000);

      // full batch; inputs scrambled right after the second capture
      a_pulse(32'h40000000, 32'hBF800000);
      tick();
      chk("a_b1_cnt", ia.sample_count, 2'd1);
      a_pulse(32'h40000000, 32'hBF800000);
      ia.bpWchange = 32'h7F800000;
      ia.bpBchange = 32'h7FC00000;
      tick();
      tick();
      chk("a_apply_nodone", ia.update_done, 1'b0);
      chk("a_apply_w_hold", ia.weights_PA, 32'h3F800000);
      tick();
      chk("a_done_t4", ia.update_done, 1'b1);
      chk("a_upd_w", ia.weights_PA, 32'h00000000);
      chk("a_upd_b", ia.biases_PA, 32'h3F800000);
      chk("a_done_busy", ia.busy, 1'b1);
      tick();
      chk("a_done_pulse", ia.update_done, 1'b0);
      chk("a_post_cnt", ia.sample_count, 2'd0);
      chk("a_post_busy", ia.busy, 1'b0);

      // abort during SCALE
      a_pulse(32'h40000000, 32'hBF800000);
      tick();
      a_pulse(32'h40000000, 32'hBF800000);
      tick();
      chk("a_scale_cnt", ia.sample_count, 2'd2);
      chk("a_scale_busy", ia.busy, 1'b1);
      ia.init = 1'b1;
      tick();
      ia.init = 1'b0;
      chk("a_abort_done", ia.update_done, 1'b0);
      chk("a_abort_busy", ia.busy, 1'b0);
      chk("a_abort_cnt", ia.sample_count, 2'd0);
      chk("a_abort_w", ia.weights_PA, 32'h3F800000);
      chk("a_abort_b", ia.biases_PA, 32'h3F000000);
      tick();
      chk("a_abort_nodone", ia.update_done, 1'b0);

      // clean batch after abort
      a_pulse(32'h40000000, 32'hBF800000);
      tick();
      a_pulse(32'h40000000, 32'hBF800000);
      tick();
      tick();
      tick();
      chk("a_clean_done", ia.update_done, 1'b1);
      chk("a_clean_w", ia.weights_PA, 32'h00000000);
      chk("a_clean_b", ia.biases_PA, 32'h3F800000);
      tick();

      // B: serial apply across three kernels
      ib.bpWchange = {32'h40400000, 32'h40000000, 32'h3F800000};
      ib.bpBchange = {32'hBF800000, 32'h00000000, 32'h3F000000};
      ib.grad_valid = 1'b1;
      tick();
      ib.grad_valid = 1'b0;
      ib.bpWchange = {3{32'h7F800000}};
      ib.bpBchange = {3{32'h7F800000}};
      chk("b_busy", ib.busy, 1'b1);
      repeat (5) tick();
      tick();
      chk("b_t7_w", ib.weights_PA, 96'h0);
      tick();
      chk("b_t8_w", ib.weights_PA,
          {32'h00000000, 32'h00000000, 32'hBF800000});
      tick();
      chk("b_t9_w", ib.weights_PA,
          {32'h00000000, 32'hC0000000, 32'hBF800000});
      chk("b_t9_nodone", ib.update_done, 1'b0);
      tick();
      chk("b_t10_w", ib.weights_PA,
          {32'hC0400000, 32'hC0000000, 32'hBF800000});
      chk("b_t10_b", ib.biases_PA,
          {32'h3F800000, 32'h00000000, 32'hBF000000});
      chk("b_t10_done", ib.update_done, 1'b1);
      tick();
      chk("b_post_done", ib.update_done, 1'b0);
      chk("b_post_busy", ib.busy, 1'b0);
      chk("b_post_cnt", ib.sample_count, 1'b0);

      // C: overrun on back-to-back grad_valid
      ic.bpWchange = {3{32'h3F800000}};
      ic.bpBchange = {3{32'h3F800000}};
      ic.grad_valid = 1'b1;
      tick();
      chk("c_ovr_pre", ic.overrun, 1'b0);
      tick();
      ic.grad_valid = 1'b0;
      chk("c_ovr_pulse", ic.overrun, 1'b1);
      tick();
      chk("c_ovr_end", ic.overrun, 1'b0);
      chk("c_busy_k2", ic.busy, 1'b1);
      tick();
      chk("c_idle", ic.busy, 1'b0);
      chk("c_cnt", ic.sample_count, 3'd1);
      chk("c_w_hold", ic.weights_PA, 96'h0);
      tick();
      chk("c_cnt_hold", ic.sample_count, 3'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pa_grad_update.md
Name: pa_grad_update

Overview:
- Consumer end of the parallel-adapter backprop interface.
- Captures per-kernel weight/bias gradients (bpWchange/bpBchange) each time the adapter pulses done_BP, and accumulates them over a mini-batch.
- At end of batch, applies a scaled SGD step and drives the updated weights_PA/biases_PA back into the adapter for the next forward pass.
- All arithmetic is IEEE-754 single precision via the existing combinational FP add/mult wrappers. Kernels are processed serially, one per cycle, to share one adder and one multiplier.

Parameters:
- PA_KERNELS, 1, number of adapter kernels (one weight and one bias each)
- BATCH, 4, samples accumulated per update (>=1)
- LR_SCALED, 32'h3C23D70A, learning rate divided by BATCH, FP32 bit pattern (0.01)
- INIT_W, 32'h00000000, FP32 initial value loaded into every weight
- INIT_B, 32'h00000000, FP32 initial value loaded into every bias
- BW, 31, MSB index of FP32 word

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- init  in  1  synchronous reload of INIT_W/INIT_B; clears accumulators and sample count
- grad_valid  in  1  single-cycle pulse; connect to adapter done_BP
- bpWchange  in  [PA_KERNELS-1:0][BW:0]  weight gradients
- bpBchange  in  [PA_KERNELS-1:0][BW:0]  bias gradients
- weights_PA  out  [PA_KERNELS-1:0][BW:0]  current weights
- biases_PA  out  [PA_KERNELS-1:0][BW:0]  current biases
- busy  out  1  high in any state other than S_IDLE
- update_done  out  1  one-cycle pulse after a batch update is written
- overrun  out  1  one-cycle pulse when grad_valid arrives while busy
- sample_count  out  $clog2(BATCH+1)  samples accumulated in current batch

Behaviour:
- Reset values: weights_PA=INIT_W, biases_PA=INIT_B, accumulators=0, sample_count=0, busy=0, update_done=0, overrun=0, state=S_IDLE, kernel index k=0.
- States:
  - S_IDLE -> S_ACC on grad_valid. In that cycle, capture bpWchange/bpBchange into holding registers. Inputs are never read after the capture cycle.
  - S_ACC: accW[k] += capW[k] and accB[k] += capB[k], one kernel per cycle, k = 0..PA_KERNELS-1. After the last kernel, sample_count increments. If the new count equals BATCH, go to S_SCALE; otherwise go to S_IDLE.
  - S_SCALE: accW[k] = accW[k]*LR_SCALED and accB[k] = accB[k]*LR_SCALED, one kernel per cycle.
  - S_APPLY: weights_PA[k] = weights_PA[k] + (accW[k] with sign bit inverted); same for biases. One kernel per cycle. Each output word changes only in its own APPLY cycle.
  - S_DONE: update_done=1 for one cycle; accumulators cleared to +0.0; sample_count=0; -> S_IDLE.
- Latency:
  - Non-final sample: grad_valid at cycle t; busy cycles t+1..t+PA_KERNELS; ready again at t+PA_KERNELS+1.
  - Final sample: update_done at t+3*PA_KERNELS+1.
- Arithmetic: round-to-nearest-even (RndMode 00). Subtraction is an add with the sign bit flipped. No saturation; inf/NaN propagate unchanged.
- grad_valid while busy: sample dropped, no state change, overrun pulses the following cycle.
- grad_valid in the same cycle S_DONE exits: treated as busy (dropped, overrun).
- init has priority over grad_valid and over every state. In any state it returns the FSM to S_IDLE next cycle, reloads INIT values, clears accumulators, count and k, and suppresses update_done. A partially applied update is discarded.
- Asynchronous rst mid-operation: immediate return to reset values.
- BATCH=1: every accepted sample triggers SCALE/APPLY.
- weights_PA/biases_PA must be treated by the adapter as stable only while busy=0.

Test Plan:
- Reset/init: assert rst with INIT_W=3F800000, INIT_B=3F000000 -> weights_PA=3F800000, biases_PA=3F000000, busy=0, sample_count=0. Corrupt state, pulse init -> same values next cycle.
- Batch update: BATCH=2, LR_SCALED=3E800000 (0.25), INIT_W=1.0, INIT_B=0.5, PA_KERNELS=1.
  - Two grad_valid pulses with bpW=40000000 (2.0) and bpB=BF800000 (-1.0).
  - Expect weights_PA=00000000 (0.0) and biases_PA=3F800000 (1.0).
  - update_done exactly 4 cycles after the second pulse; sample_count 1 after the first sample, 0 after the update.
- Multi-kernel serial: PA_KERNELS=3, BATCH=1, LR_SCALED=3F800000.
  - Grads W={3F800000,40000000,40400000}, initial weights 0 -> weights {BF800000,C0000000,C0400000}.
  - Each kernel word changes in a distinct APPLY cycle; update_done at t+10.
- Overrun: PA_KERNELS=3; second grad_valid 1 cycle after the first -> overrun pulse, sample_count ends at 1, weights unchanged.
- Abort: init asserted during S_SCALE -> no update_done, weights=INIT_W, sample_count=0. A following full batch produces the correct update from clean accumulators.
- Change gradient inputs the cycle after grad_valid: the update must use the captured values only.
